// File: rtl/script_runner.sv
// ---------------------------------------------------------------------------
// script_runner
//   Executes a small byte-code script from an external script memory and
//   drives the UART transmit handshake. The instruction set is:
//     000 END     finish and hold DONE
//     001 SEND    offer argument byte to the UART, wait for data_ready
//     010 WAIT    idle for argument * TICKS_PER_UNIT clocks
//     011 JUMP    pc <= argument
//     100 WAITFB  wait until the UART receives a byte equal to argument
//     101-111     illegal -> ERROR
//   Instruction fields: opcode = script[15:13], argument = script[7:0].
//
// Ports
//   uart_clk        16x baud clock, the only clock
//   reset_n         synchronous active-low reset
//   script_mode     high while a script is being loaded (forces abort)
//   script[15:0]    instruction at pc, valid one cycle after pc changes
//   run_enable      level request to execute the script
//   data_ready      one-cycle pulse: offered byte has been transmitted
//   feedback_valid  received-byte strobe
//   feedback_bits   received byte
//   pc[7:0]         instruction address to the script memory
//   data_send[7:0]  byte offered to the UART
//   data_req        data_send holds a byte awaiting transmission
//   running         executing (FETCH/DECODE/SEND/WAIT/FBWAIT)
//   done            script finished with END
//   error           illegal opcode hit; pc holds its address
// ---------------------------------------------------------------------------
module script_runner #(
  parameter int unsigned TICKS_PER_UNIT = 15360
) (
  input  logic        uart_clk,
  input  logic        reset_n,
  input  logic        script_mode,
  input  logic [15:0] script,
  input  logic        run_enable,
  input  logic        data_ready,
  input  logic        feedback_valid,
  input  logic [7:0]  feedback_bits,
  output logic [7:0]  pc,
  output logic [7:0]  data_send,
  output logic        data_req,
  output logic        running,
  output logic        done,
  output logic        error
);

  // Counter must hold 255 * TICKS_PER_UNIT.
  localparam int unsigned CNT_MAX = 255 * TICKS_PER_UNIT;
  localparam int          CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TICKS = CNT_W'(TICKS_PER_UNIT);

  localparam logic [2:0] OP_END    = 3'b000;
  localparam logic [2:0] OP_SEND   = 3'b001;
  localparam logic [2:0] OP_WAIT   = 3'b010;
  localparam logic [2:0] OP_JUMP   = 3'b011;
  localparam logic [2:0] OP_WAITFB = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_SEND,
    S_WAIT,
    S_FBWAIT,
    S_DONE,
    S_ERROR
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       pc_q, pc_d;
  logic [7:0]       data_send_q, data_send_d;
  logic             data_req_q, data_req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       arg_q, arg_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic [2:0] opcode;
  logic [7:0] argument;
  logic       abort;

  // script[12:8] carries no meaning for this instruction set.
  logic       unused_script_bits;
  assign unused_script_bits = ^script[12:8];

  assign opcode   = script[15:13];
  assign argument = script[7:0];
  assign abort    = script_mode | ~run_enable;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    data_send_d = data_send_q;
    data_req_d  = data_req_q;
    cnt_d       = cnt_q;
    arg_d       = arg_q;

    // Abort wins over every in-flight handshake, including a data_ready or
    // feedback match in the same cycle; a withdrawn byte is not retried.
    if (state_q != S_IDLE && abort) begin
      state_d     = S_IDLE;
      pc_d        = 8'd0;
      data_send_d = 8'd0;
      data_req_d  = 1'b0;
      cnt_d       = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (run_enable && !script_mode) begin
            pc_d    = 8'd0;
            state_d = S_FETCH;
          end
        end

        // One cycle for the script memory to present mem[pc].
        S_FETCH: state_d = S_DECODE;

        S_DECODE: begin
          arg_d = argument;
          unique case (opcode)
            OP_END: state_d = S_DONE;
            OP_SEND: begin
              data_send_d = argument;
              data_req_d  = 1'b1;
              state_d     = S_SEND;
            end
            OP_WAIT: begin
              // A zero-length wait skips the WAIT state entirely.
              if (argument == 8'd0) begin
                pc_d    = pc_q + 8'd1;
                state_d = S_FETCH;
              end else begin
                cnt_d   = CNT_W'(argument) * TICKS;
                state_d = S_WAIT;
              end
            end
            OP_JUMP: begin
              pc_d    = argument;
              state_d = S_FETCH;
            end
            OP_WAITFB: state_d = S_FBWAIT;
            default:   state_d = S_ERROR;
          endcase
        end

        S_SEND: begin
          if (data_ready) begin
            pc_d        = pc_q + 8'd1;
            data_req_d  = 1'b0;
            data_send_d = 8'd0;
            state_d     = S_FETCH;
          end
        end

        // Leaving on count==1 makes WAIT last exactly the loaded count.
        S_WAIT: begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            pc_d    = pc_q + 8'd1;
            state_d = S_FETCH;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        S_FBWAIT: begin
          if (feedback_valid && feedback_bits == arg_q) begin
            pc_d    = pc_q + 8'd1;
            state_d = S_FETCH;
          end
        end

        // Held until abort (run_enable low or script_mode high).
        S_DONE:  state_d = S_DONE;
        S_ERROR: state_d = S_ERROR;

        default: state_d = S_IDLE;
      endcase
    end

    // Status flags are registered copies of the next state.
    running_d = (state_d == S_FETCH)  || (state_d == S_DECODE) ||
                (state_d == S_SEND)   || (state_d == S_WAIT)   ||
                (state_d == S_FBWAIT);
    done_d    = (state_d == S_DONE);
    error_d   = (state_d == S_ERROR);
  end

  always_ff @(posedge uart_clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pc_q        <= 8'd0;
      data_send_q <= 8'd0;
      data_req_q  <= 1'b0;
      cnt_q       <= '0;
      arg_q       <= 8'd0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      data_send_q <= data_send_d;
      data_req_q  <= data_req_d;
      cnt_q       <= cnt_d;
      arg_q       <= arg_d;
      running_q   <= running_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign pc        = pc_q;
  assign data_send = data_send_q;
  assign data_req  = data_req_q;
  assign running   = running_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: doc/script_runner.md
SCRIPT_RUNNER -- requirements
Module: script_runner

Interface
REQ-001 Parameter TICKS_PER_UNIT, default 15360, gives uart_clk cycles per WAIT unit (0.1 s at 153600 Hz).
REQ-002 uart_clk  input  1  the only clock, 16x baud UART clock; all logic on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 script_mode  input  1  high while ScriptMem loads a script over UART.
REQ-005 script  input  16  instruction at address pc; valid one cycle after pc changes.
REQ-006 run_enable  input  1  level request to execute the script (switch).
REQ-007 data_ready  input  1  one-cycle pulse from UART when the offered byte has been transmitted.
REQ-008 feedback_valid  input  1  received-byte strobe from UART.
REQ-009 feedback_bits  input  8  received byte; qualified by feedback_valid.
REQ-010 pc  output  8  instruction address to ScriptMem.
REQ-011 data_send  output  8  byte offered to UART transmit.
REQ-012 data_req  output  1  high while data_send holds a byte awaiting transmission.
REQ-013 running  output  1  high in any executing state (FETCH, DECODE, SEND, WAIT, FBWAIT).
REQ-014 done  output  1  high in DONE.
REQ-015 error  output  1  high in ERROR.

Function
REQ-016 Instruction fields: opcode = script[15:13]; argument = script[7:0]; script[12:8] ignored.
REQ-017 Opcodes: 000 END, 001 SEND, 010 WAIT, 011 JUMP, 100 WAITFB; 101-111 illegal.
REQ-018 States: IDLE, FETCH, DECODE, SEND, WAIT, FBWAIT, DONE, ERROR; registered one-hot or binary, implementer's choice.
REQ-019 IDLE: when run_enable=1 and script_mode=0, set pc=0 and go to FETCH next cycle.
REQ-020 FETCH: lasts exactly one cycle, then DECODE; DECODE samples script and argument into registers.
REQ-021 END in DECODE -> DONE; pc unchanged.
REQ-022 SEND in DECODE -> SEND; data_send=argument and data_req=1 from the cycle entering SEND.
REQ-023 In SEND, data_send and data_req stay stable until a cycle with data_ready=1; that cycle pc<=pc+1, data_req<=0, data_send<=0, next state FETCH.
REQ-024 data_ready outside SEND is ignored.
REQ-025 WAIT in DECODE: load a down-counter with argument*TICKS_PER_UNIT; argument=0 -> pc+1, FETCH immediately, with no WAIT cycle.
REQ-026 In WAIT, the counter decrements each cycle; on reaching 1 -> pc+1, FETCH, so WAIT occupies exactly argument*TICKS_PER_UNIT cycles.
REQ-027 The counter is wide enough for 255*TICKS_PER_UNIT without overflow.
REQ-028 JUMP in DECODE: pc<=argument, next state FETCH; a jump to itself loops indefinitely and is legal.
REQ-029 WAITFB in DECODE -> FBWAIT; a feedback_valid pulse during DECODE is not counted.
REQ-030 FBWAIT: advance (pc+1, FETCH) on the first cycle with feedback_valid=1 and feedback_bits==argument; non-matching bytes are ignored.
REQ-031 Illegal opcode in DECODE -> ERROR; pc holds the offending address.
REQ-032 pc increments modulo 256 (255 -> 0).
REQ-033 DONE/ERROR are held while run_enable=1; run_enable=0 -> IDLE next cycle, clearing done/error.
REQ-034 Abort: script_mode=1 or run_enable=0 in any non-IDLE state -> next cycle IDLE, pc=0, data_req=0, data_send=0, counter cleared.
REQ-035 Abort takes priority over every other transition, including a simultaneous data_ready or feedback match.
REQ-036 Abort during SEND withdraws data_req even if the UART is mid-byte; that byte is not retried.
REQ-037 All outputs are registered.

Reset
REQ-038 reset_n=0 at a rising edge -> IDLE, pc=0, data_send=0, data_req=0, running=0, done=0, error=0, counter=0, on the following cycle.
REQ-039 Reset overrides abort and all other transitions and is honoured mid-operation in any state.

Verification
REQ-040 Script {SEND 0x21, SEND 0x43, END}, run_enable=1, data_ready pulsed 5 cycles after each data_req rise -> data_send 0x21 then 0x43, pc 0,1,2, done=1, data_req low between bytes.
REQ-041 TICKS_PER_UNIT=4, script {WAIT 3, END} -> 12 cycles in WAIT, then FETCH pc=1, done; WAIT 0 -> zero WAIT cycles.
REQ-042 Script {WAITFB 0x5A, END}, feedback 0x11 then 0x5A -> stays in FBWAIT on 0x11, advances on the 0x5A cycle, done=1.
REQ-043 Script {JUMP 0x03, x, x, opcode 111} -> pc 0 then 3, error=1, pc=3; run_enable low -> IDLE, error=0.
REQ-044 Abort during SEND with data_ready in the same cycle as script_mode=1 -> IDLE, pc=0, data_req=0, no pc increment.
REQ-045 reset_n low for 1 cycle during WAIT -> all outputs at reset values next cycle; run_enable still high -> restart at pc=0.
